// File: rtl/random_shot_dispatcher.sv
// Turns the slow random index into one lane-based shot request at a time, with a
// cooldown between shots and no back-to-back repeat of the same lane.
module random_shot_dispatcher #(
  parameter int unsigned NUM_LANES = 24,
  parameter int unsigned LANE_W    = 26,
  parameter int unsigned X_OFFSET  = 16,
  parameter int unsigned COOLDOWN  = 45000000,
  parameter bit          AVOID_REP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [8:0]  rnd_in,
  input  logic        shot_ready,
  output logic        shot_valid,
  output logic [4:0]  shot_lane,
  output logic [9:0]  shot_x,
  output logic        busy,
  output logic [15:0] shots_issued
);

  localparam int unsigned CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN - 1);
  localparam logic [8:0] LANES_9 = 9'(NUM_LANES);
  localparam logic [4:0] LAST_LANE = 5'(NUM_LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REDUCE,
    S_PICK,
    S_OFFER
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       rem_q, rem_d;
  logic [4:0]       last_q, last_d;
  logic [4:0]       lane_q, lane_d;
  logic [9:0]       x_q, x_d;
  logic             valid_q, valid_d;
  logic [15:0]      shots_issued_q, shots_issued_d;

  logic [4:0]       lane_pick;
  logic [31:0]      x_full;

  // Lane choice only matters in PICK, where rem_q is already below NUM_LANES.
  always_comb begin
    lane_pick = rem_q[4:0];
    if (AVOID_REP && (lane_pick == last_q)) begin
      lane_pick = (lane_pick == LAST_LANE) ? 5'd0 : lane_pick + 5'd1;
    end
    x_full = X_OFFSET + LANE_W * {27'd0, lane_pick};
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rem_d          = rem_q;
    last_d         = last_q;
    lane_d         = lane_q;
    x_d            = x_q;
    valid_d        = valid_q;
    shots_issued_d = shots_issued_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          rem_d   = rnd_in;
          state_d = S_REDUCE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_REDUCE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (rem_q >= LANES_9) begin
          rem_d = rem_q - LANES_9;
        end else begin
          state_d = S_PICK;
        end
      end
      S_PICK: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          lane_d  = lane_pick;
          x_d     = x_full[9:0];
          last_d  = lane_pick;
          valid_d = 1'b1;
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        // The offer is never dropped once made; enable only decides where to go after it.
        if (valid_q && shot_ready) begin
          valid_d = 1'b0;
          if (shots_issued_q != 16'hFFFF) begin
            shots_issued_d = shots_issued_q + 16'd1;
          end
          if (enable) begin
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      rem_q          <= '0;
      last_q         <= 5'h1F;
      lane_q         <= '0;
      x_q            <= '0;
      valid_q        <= 1'b0;
      shots_issued_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rem_q          <= rem_d;
      last_q         <= last_d;
      lane_q         <= lane_d;
      x_q            <= x_d;
      valid_q        <= valid_d;
      shots_issued_q <= shots_issued_d;
    end
  end

  assign shot_valid   = valid_q;
  assign shot_lane    = lane_q;
  assign shot_x       = x_q;
  assign busy         = (state_q != S_IDLE);
  assign shots_issued = shots_issued_q;

endmodule
